axi_wr_arbiter: RTL and testbench
=================================

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h4000_0000, which is the offset added to every requester address.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports reqN_addr, input, 32 bits, one each for N=0 and N=1: byte address of the write, relative to BASE_ADDR.
REQ-005 The block SHALL have ports reqN_data, input, 32 bits, N=0,1: write data.
REQ-006 The block SHALL have ports reqN_valid, input, 1 bit, N=0,1: the write request is pending.
REQ-007 The block SHALL have ports reqN_ready, output, 1 bit, N=0,1: the request is accepted in this cycle.
REQ-008 The block SHALL have ports reqN_done, output, 1 bit, N=0,1: one-cycle pulse when the write response returns.
REQ-009 The block SHALL have ports reqN_err, output, 1 bit, N=0,1: the response was not OKAY; valid while reqN_done is high.
REQ-010 The block SHALL have the following AXI4 write ports:
- m_axi_awaddr (output, 32 bits), m_axi_awlen (output, 8 bits), m_axi_awsize (output, 3 bits), m_axi_awburst (output, 2 bits);
- m_axi_awvalid (output, 1 bit), m_axi_awready (input, 1 bit);
- m_axi_wdata (output, 32 bits), m_axi_wstrb (output, 4 bits), m_axi_wlast (output, 1 bit);
- m_axi_wvalid (output, 1 bit), m_axi_wready (input, 1 bit);
- m_axi_bresp (input, 2 bits), m_axi_bvalid (input, 1 bit), m_axi_bready (output, 1 bit).
REQ-011 The block SHALL have port busy, output, 1 bit: the state is not IDLE.

Function
REQ-012 The AXI constant outputs SHALL be awlen=0, awsize=3'h2, awburst=2'h1, wstrb=4'b1111, and m_axi_wlast=m_axi_wvalid.
REQ-013 The state machine SHALL have three states: IDLE, SEND and RESP.
REQ-014 In IDLE, the grant SHALL be computed combinationally:
- only one reqN_valid high: that requester is granted;
- both high: the requester not granted last time is granted (round-robin); after reset, req0 is treated as last granted, so req1 wins the first tie.
REQ-015 In IDLE, reqN_ready SHALL equal the grant for N; both ready outputs SHALL be 0 outside IDLE, and at most one SHALL be high in any cycle.
REQ-016 On reqN_valid & reqN_ready, the block SHALL:
- register BASE_ADDR + reqN_addr as awaddr (modulo 2^32, carry dropped);
- register reqN_data as wdata;
- record the owner N and update last-granted to N;
- set m_axi_awvalid=1 and m_axi_wvalid=1;
- go to SEND.
REQ-017 In SEND, m_axi_awvalid SHALL clear on the edge after awvalid & awready, and m_axi_wvalid SHALL clear on the edge after wvalid & wready; the two handshakes SHALL be independent, in either order or in the same cycle.
REQ-018 m_axi_awaddr and m_axi_wdata SHALL stay stable while their valid is high.
REQ-019 When both handshakes have completed (including completion in the same cycle), the block SHALL go to RESP with m_axi_bready=1 on the next edge.
REQ-020 In RESP, on bvalid & bready the block SHALL, on that edge:
- clear bready;
- pulse reqN_done for the owner for exactly one cycle;
- set reqN_err = (bresp != 2'b00);
- return to IDLE.
REQ-021 m_axi_bvalid outside RESP SHALL be ignored.
REQ-022 Minimum latency SHALL be as follows, with zero-wait slaves and acceptance at cycle T:
- awvalid and wvalid high at T+1;
- bready high at T+2;
- reqN_done at T+3, the cycle after the B handshake;
- a new acceptance possible at T+3.
REQ-023 Only one transaction SHALL be outstanding at any time.
REQ-024 A requester that drops reqN_valid before ready SHALL lose no state; no request SHALL be accepted without a valid/ready handshake.
REQ-025 busy SHALL be 1 in SEND and RESP, and 0 in IDLE.

Reset
REQ-026 While rst_i is high at a rising edge, the block SHALL:
- go to state IDLE;
- clear awvalid, wvalid, bready, all reqN_done, all reqN_err and busy;
- clear awaddr and wdata to 0;
- set last-granted to req0.
REQ-027 A reset during SEND or RESP SHALL abandon the in-flight transaction, with no done pulse; the first request after reset SHALL be arbitrated normally.

Verification
REQ-028 Single write: req0 with addr=0x10, data=0xA5A5_A5A5, zero-wait slave, bresp=0 -> awaddr=0x4000_0010, wdata=0xA5A5_A5A5, req0_done at T+3, req0_err=0.
REQ-029 Tie: both valid continuously for 4 transactions -> grants req1, req0, req1, req0 in that order.
REQ-030 Split handshakes: awready held low 3 cycles after wready -> wvalid drops first, awvalid held stable with the same address, bready asserted only after awvalid drops.
REQ-031 Error: bresp=2'b10 for a req1 write -> req1_done=1 and req1_err=1 for one cycle; req0 outputs stay 0.
REQ-032 Wraparound: BASE_ADDR=32'hFFFF_FFF0, addr=0x20 -> awaddr=0x0000_0010.
REQ-033 Reset mid-SEND: rst_i high one cycle while awvalid=1 -> the next cycle shows awvalid=0, wvalid=0, busy=0 and no done pulse; a following req0 request completes normally.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - two-requester round-robin arbiter issuing single-beat AXI4 writes
module axi_wr_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_data,
    input  logic        req0_valid,
    output logic        req0_ready,
    output logic        req0_done,
    output logic        req0_err,

    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    output logic        req1_done,
    output logic        req1_err,

    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,

    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,

    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_gnt;
    logic   owner;
    logic   gnt0;
    logic   gnt1;
    logic   aw_pending;
    logic   w_pending;

    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'h2;
    assign m_axi_awburst = 2'h1;
    assign m_axi_wstrb   = 4'b1111;
    assign m_axi_wlast   = m_axi_wvalid;
    assign busy          = (state != IDLE);

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        gnt1 = 1'b0;
        gnt0 = 1'b0;
        if (state == IDLE) begin
            gnt1 = req1_valid & (~req0_valid | ~last_gnt);
            gnt0 = req0_valid & ~gnt1;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Whether each channel is still waiting for its handshake after this edge.
    assign aw_pending = m_axi_awvalid & ~m_axi_awready;
    assign w_pending  = m_axi_wvalid & ~m_axi_wready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            last_gnt      <= 1'b0;
            owner         <= 1'b0;
            m_axi_awaddr  <= 32'd0;
            m_axi_wdata   <= 32'd0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            req0_done     <= 1'b0;
            req1_done     <= 1'b0;
            req0_err      <= 1'b0;
            req1_err      <= 1'b0;
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            req0_err  <= 1'b0;
            req1_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt1) begin
                        m_axi_awaddr  <= BASE_ADDR + req1_addr;
                        m_axi_wdata   <= req1_data;
                        owner         <= 1'b1;
                        last_gnt      <= 1'b1;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        state         <= SEND;
                    end else if (gnt0) begin
                        m_axi_awaddr  <= BASE_ADDR + req0_addr;
                        m_axi_wdata   <= req0_data;
                        owner         <= 1'b0;
                        last_gnt      <= 1'b0;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    m_axi_awvalid <= aw_pending;
                    m_axi_wvalid  <= w_pending;
                    if (!aw_pending && !w_pending) begin
                        m_axi_bready <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        if (owner) begin
                            req1_done <= 1'b1;
                            req1_err  <= (m_axi_bresp != 2'b00);
                        end else begin
                            req0_done <= 1'b1;
                            req0_err  <= (m_axi_bresp != 2'b00);
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb/tb_axi_wr_arbiter.sv - scoreboard bench for axi_wr_arbiter
module tb_axi_wr_arbiter;

    typedef struct {
        logic        owner;
        logic [31:0] awaddr;
        logic [31:0] awaddr2;
        logic [31:0] wdata;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } item_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] req0_addr, req0_data, req1_addr, req1_data;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err;
    logic [31:0] m_axi_awaddr, m_axi_wdata;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst, m_axi_bresp;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, busy;

    logic        x_req0_ready, x_req1_ready, x_req0_done, x_req1_done, x_req0_err, x_req1_err;
    logic [31:0] x_awaddr, x_wdata;
    logic [7:0]  x_awlen;
    logic [2:0]  x_awsize;
    logic [1:0]  x_awburst;
    logic [3:0]  x_wstrb;
    logic        x_awvalid, x_wlast, x_wvalid, x_bready, x_busy;

    logic [1:0]  bresp_cfg;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;

    item_t p0_q[$];
    item_t p1_q[$];
    exp_t  aw_q[$];
    exp_t  w_q[$];
    exp_t  b_q[$];
    int    acc_q[$];

    axi_wr_arbiter u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_addr(req0_addr), .req0_data(req0_data), .req0_valid(req0_valid),
        .req0_ready(req0_ready), .req0_done(req0_done), .req0_err(req0_err),
        .req1_addr(req1_addr), .req1_data(req1_data), .req1_valid(req1_valid),
        .req1_ready(req1_ready), .req1_done(req1_done), .req1_err(req1_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .busy(busy)
    );

    // Second instance shares all inputs; only its wrapped address is checked.
    axi_wr_arbiter #(.BASE_ADDR(32'hFFFF_FFF0)) u_wrap (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_addr(req0_addr), .req0_data(req0_data), .req0_valid(req0_valid),
        .req0_ready(x_req0_ready), .req0_done(x_req0_done), .req0_err(x_req0_err),
        .req1_addr(req1_addr), .req1_data(req1_data), .req1_valid(req1_valid),
        .req1_ready(x_req1_ready), .req1_done(x_req1_done), .req1_err(x_req1_err),
        .m_axi_awaddr(x_awaddr), .m_axi_awlen(x_awlen), .m_axi_awsize(x_awsize),
        .m_axi_awburst(x_awburst), .m_axi_awvalid(x_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(x_wdata), .m_axi_wstrb(x_wstrb), .m_axi_wlast(x_wlast),
        .m_axi_wvalid(x_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(x_bready),
        .busy(x_busy)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_req(input int port, input logic [31:0] addr, input logic [31:0] data);
        item_t it;
        it.addr = addr;
        it.data = data;
        if (port == 0) p0_q.push_back(it);
        else p1_q.push_back(it);
    endtask

    task automatic expect_txn(input logic owner, input logic [31:0] awaddr, input logic [31:0] awaddr2,
                              input logic [31:0] wdata, input logic err, input int lat);
        exp_t e;
        e.owner = owner; e.awaddr = awaddr; e.awaddr2 = awaddr2;
        e.wdata = wdata; e.err = err; e.lat = lat;
        aw_q.push_back(e);
        w_q.push_back(e);
        b_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            if (p0_q.size() == 0 && p1_q.size() == 0 && b_q.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        @(negedge clk_i);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s_timeout: transactions still pending %0d, required 0", name, b_q.size());
        end
    endtask

    task automatic wait_awvalid(input string name);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (m_axi_awvalid) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s_timeout: awvalid never rose, required 1", name);
        end
    endtask

    // Requester drivers: present the head of each port queue, pop on handshake.
    logic acc0, acc1;
    initial begin
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        forever begin
            @(negedge clk_i);
            acc0 = req0_valid & req0_ready;
            @(posedge clk_i);
            #1;
            if (acc0 && p0_q.size() > 0) void'(p0_q.pop_front());
            if (p0_q.size() > 0) begin
                req0_valid = 1; req0_addr = p0_q[0].addr; req0_data = p0_q[0].data;
            end else begin
                req0_valid = 0;
            end
        end
    end

    initial begin
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        forever begin
            @(negedge clk_i);
            acc1 = req1_valid & req1_ready;
            @(posedge clk_i);
            #1;
            if (acc1 && p1_q.size() > 0) void'(p1_q.pop_front());
            if (p1_q.size() > 0) begin
                req1_valid = 1; req1_addr = p1_q[0].addr; req1_data = p1_q[0].data;
            end else begin
                req1_valid = 0;
            end
        end
    end

    // Zero-wait B channel: answer in the same cycle bready is seen.
    initial begin
        m_axi_bvalid = 0; m_axi_bresp = 0;
        forever begin
            @(negedge clk_i);
            m_axi_bvalid = m_axi_bready;
            m_axi_bresp  = m_axi_bready ? bresp_cfg : 2'b00;
        end
    end

    // Monitor: protocol rules every cycle, scoreboard pops on each handshake.
    logic        prev_aw_hold = 0;
    logic [31:0] prev_awaddr = 0;
    initial begin
        exp_t e;
        int   t_acc;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_aw_hold = 0;
                continue;
            end
            check("ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
            check("ready_busy", {31'd0, busy & (req0_ready | req1_ready)}, 32'd0);
            check("wlast", {31'd0, m_axi_wlast}, {31'd0, m_axi_wvalid});
            check("bready_early", {31'd0, m_axi_bready & (m_axi_awvalid | m_axi_wvalid)}, 32'd0);
            if (prev_aw_hold && m_axi_awvalid) check("awaddr_stable", m_axi_awaddr, prev_awaddr);
            prev_aw_hold = m_axi_awvalid & ~m_axi_awready;
            prev_awaddr  = m_axi_awaddr;

            if ((req0_valid & req0_ready) | (req1_valid & req1_ready)) acc_q.push_back(cyc);

            if (m_axi_awvalid & m_axi_awready) begin
                if (aw_q.size() == 0) check("aw_unexpected", 32'd1, 32'd0);
                else begin
                    e = aw_q.pop_front();
                    check("awaddr", m_axi_awaddr, e.awaddr);
                    check("awaddr_wrap", x_awaddr, e.awaddr2);
                end
            end
            if (m_axi_wvalid & m_axi_wready) begin
                if (w_q.size() == 0) check("w_unexpected", 32'd1, 32'd0);
                else begin
                    e = w_q.pop_front();
                    check("wdata", m_axi_wdata, e.wdata);
                end
            end
            if (req0_done | req1_done) begin
                if (b_q.size() == 0) check("done_unexpected", {30'd0, req1_done, req0_done}, 32'd0);
                else begin
                    e = b_q.pop_front();
                    check("done_owner", {30'd0, req1_done, req0_done}, e.owner ? 32'd2 : 32'd1);
                    check("err", {30'd0, req1_err, req0_err},
                          e.err ? (e.owner ? 32'd2 : 32'd1) : 32'd0);
                    t_acc = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
                    if (e.lat != 0) check("latency", cyc - t_acc, e.lat);
                end
            end
        end
    end

    initial begin
        rst_i = 1; m_axi_awready = 1; m_axi_wready = 1; bresp_cfg = 2'b00;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 0;
        @(negedge clk_i);
        check("rst_awvalid", {31'd0, m_axi_awvalid}, 32'd0);
        check("rst_wvalid", {31'd0, m_axi_wvalid}, 32'd0);
        check("rst_bready", {31'd0, m_axi_bready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done_err", {28'd0, req1_done, req0_done, req1_err, req0_err}, 32'd0);
        check("rst_awaddr", m_axi_awaddr, 32'd0);
        check("rst_wdata", m_axi_wdata, 32'd0);
        check("const_awlen", {24'd0, m_axi_awlen}, 32'd0);
        check("const_awsize", {29'd0, m_axi_awsize}, 32'd2);
        check("const_awburst", {30'd0, m_axi_awburst}, 32'd1);
        check("const_wstrb", {28'd0, m_axi_wstrb}, 32'hF);

        // Single zero-wait write from req0.
        add_req(0, 32'h10, 32'hA5A5_A5A5);
        expect_txn(0, 32'h4000_0010, 32'h0000_0000, 32'hA5A5_A5A5, 0, 3);
        wait_idle("single");

        // Continuous tie: req0 was last granted, so req1 leads.
        add_req(1, 32'h100, 32'h1111_0001);
        add_req(1, 32'h104, 32'h1111_0002);
        add_req(0, 32'h200, 32'h2222_0001);
        add_req(0, 32'h204, 32'h2222_0002);
        expect_txn(1, 32'h4000_0100, 32'h0000_00F0, 32'h1111_0001, 0, 3);
        expect_txn(0, 32'h4000_0200, 32'h0000_01F0, 32'h2222_0001, 0, 3);
        expect_txn(1, 32'h4000_0104, 32'h0000_00F4, 32'h1111_0002, 0, 3);
        expect_txn(0, 32'h4000_0204, 32'h0000_01F4, 32'h2222_0002, 0, 3);
        wait_idle("tie");

        // Split handshakes: W completes first, AW stalls three cycles.
        @(posedge clk_i); #1 m_axi_awready = 0;
        add_req(0, 32'h30, 32'hDEAD_BEEF);
        expect_txn(0, 32'h4000_0030, 32'h0000_0020, 32'hDEAD_BEEF, 0, 0);
        wait_awvalid("split");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("split_wvalid", {31'd0, m_axi_wvalid}, 32'd0);
            check("split_awvalid", {31'd0, m_axi_awvalid}, 32'd1);
            check("split_bready", {31'd0, m_axi_bready}, 32'd0);
            check("split_awaddr", m_axi_awaddr, 32'h4000_0030);
        end
        @(posedge clk_i); #1 m_axi_awready = 1;
        wait_idle("split");

        // Error responses.
        bresp_cfg = 2'b10;
        add_req(1, 32'h40, 32'h0BAD_0001);
        expect_txn(1, 32'h4000_0040, 32'h0000_0030, 32'h0BAD_0001, 1, 3);
        wait_idle("err_slverr");
        bresp_cfg = 2'b01;
        add_req(0, 32'h44, 32'h0BAD_0002);
        expect_txn(0, 32'h4000_0044, 32'h0000_0034, 32'h0BAD_0002, 1, 3);
        wait_idle("err_exokay");
        bresp_cfg = 2'b00;

        // Wraparound on the second instance: 0xFFFF_FFF0 + 0x20.
        add_req(0, 32'h20, 32'h0000_2020);
        expect_txn(0, 32'h4000_0020, 32'h0000_0010, 32'h0000_2020, 0, 3);
        wait_idle("wrap");

        // Reset while req1's write sits in SEND; it must vanish without a done.
        @(posedge clk_i); #1 m_axi_awready = 0; m_axi_wready = 0;
        add_req(1, 32'h50, 32'h5555_0050);
        wait_awvalid("rst_mid");
        @(posedge clk_i); #1 rst_i = 1;
        aw_q.delete(); w_q.delete(); b_q.delete(); acc_q.delete();
        @(posedge clk_i); #1 rst_i = 0; m_axi_awready = 1; m_axi_wready = 1;
        @(negedge clk_i);
        check("rstmid_awvalid", {31'd0, m_axi_awvalid}, 32'd0);
        check("rstmid_wvalid", {31'd0, m_axi_wvalid}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_done", {30'd0, req1_done, req0_done}, 32'd0);
        check("rstmid_awaddr", m_axi_awaddr, 32'd0);

        // Last-granted restored to req0 by reset, so req1 wins this tie.
        add_req(0, 32'h60, 32'h6666_0060);
        add_req(1, 32'h70, 32'h7777_0070);
        expect_txn(1, 32'h4000_0070, 32'h0000_0060, 32'h7777_0070, 0, 3);
        expect_txn(0, 32'h4000_0060, 32'h0000_0050, 32'h6666_0060, 0, 3);
        wait_idle("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
